data_ram: RTL and testbench
===========================

# data_ram

Word-organised data memory for the single-cycle CPU datapath, serving loads and stores from the execute/memory stage. Stores are synchronous to the clock. Reads are combinational, so load data is valid in the same cycle the address is presented. A synchronous reset clears the entire array to zero.

## Interface
- `ADDR_BITS`, default 10: number of word-index bits. Depth is 2^ADDR_BITS 32-bit words, which is 1024 words (4 KiB) by default.
- `clock` input 1: single clock. All state changes occur on its rising edge.
- `reset` input 1: reset is synchronous and active-low. When low at a rising edge, every word is cleared to 0.
- `store` input 1: write enable, active-high, sampled on the rising edge.
- `address` input 32: byte address.
- `data` input 32: write data.
- `result` output 32: read data for the word at `address`. It is combinational.

## Operation
- Storage is an array of 2^ADDR_BITS words, 32 bits each, built from flip-flops/distributed RAM so that a single-cycle clear is possible.
- Word index is `address[ADDR_BITS+1:2]`.
  - `address[1:0]` is ignored. The memory handles whole aligned words only, with no byte or halfword lanes.
  - `address[31:ADDR_BITS+2]` is ignored, so the address space wraps and aliases modulo 4×2^ADDR_BITS bytes.
- Rising edge with `reset`=0: all words become 0. Any `store` in that cycle is discarded, because reset has priority.
- Rising edge with `reset`=1 and `store`=1: `mem[index] <= data`. All other words are unchanged.
- Rising edge with `reset`=1 and `store`=0: no state change.
- `result` = `mem[index]` at all times, with no registering and no dependence on `store`.
  - It reflects the current array contents, including a word just cleared or written.
  - It does not bypass `data` before the edge.
- No X propagation is allowed after the first reset. Contents before the first reset are undefined.

## Timing
- Write latency is 1 edge. After the edge that performs the write, `result` shows the new value once the combinational read settles, provided `address` still selects that word.
- Read latency is 0 cycles. `result` follows `address` changes combinationally within the same cycle.
- Reset takes effect at the first rising edge with `reset` low. From that edge on, `result` is 0 for every address.
  - If `reset` is held low for several cycles, the array stays 0 and stores are ignored.
- Store timing:
  - `store` held high across multiple edges rewrites the same word each edge with the current `data`.
  - `store` changing between edges has no effect.
- Write and read of the same word in one cycle: before the edge `result` is the old value, after the edge it is the new value.
- No handshake is used. The memory is always ready and never stalls.

## Test plan
- Write then read:
  - Reset low for one edge, then high.
  - Store 100 at address 4 (`store`=1 for one edge), then store 200 at address 8.
  - Set address=4, so `result`=100. Set address=8, so `result`=200.
- Reset clears: after the writes above, hold `reset` low for one edge.
  - `result` must be 0 at address 4, at address 8, and at address 0.
- Alignment and aliasing, after storing 0xDEADBEEF at address 4:
  - Addresses 5, 6 and 7 must each read 0xDEADBEEF.
  - Address 4+4096 (0x1004) must read 0xDEADBEEF.
  - Address 0 must read 0.
- Reset priority: `reset`=0 and `store`=1 with address=12 and data=0x55 on the same edge.
  - After the edge, address 12 reads 0.
- Write gating: change `data` and `address` while `store`=0 across several edges.
  - All previously stored words are unchanged.
  - `result` tracks `address` with no delay.
- Back-to-back stores: `store` high for 3 consecutive edges with data 1, 2, 3 to addresses 16, 20, 24.
  - Reads return 1, 2 and 3 respectively.
  - Rewriting address 16 with 7 then reads 7.

Source files
------------

// File: rtl/data_ram.sv
// data_ram: word-organised data memory for the single-cycle CPU datapath.
// Latency: stores take effect at the rising edge; reads are combinational (0 cycles).
// Backpressure: none; the memory is always ready and never stalls.
//
// Ports:
//   clock   - single clock, all state changes on its rising edge
//   reset   - synchronous active-low clear of the whole array (wins over store)
//   store   - write enable, active-high, sampled on the rising edge
//   address - byte address; only bits [ADDR_BITS+1:2] select the word
//   data    - write data
//   result  - combinational read data for the word selected by address
module data_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        store,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] result
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Built from flops rather than block RAM so the whole array can be cleared
  // in a single cycle.
  logic [31:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] index;

  // Byte lanes and high address bits are dropped: accesses are whole aligned
  // words and the address space aliases modulo the memory size.
  assign index = address[ADDR_BITS+1:2];

  logic unused_addr;
  assign unused_addr = ^{address[31:ADDR_BITS+2], address[1:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (store) begin
      mem[index] <= data;
    end
  end

  // No bypass of data: a same-cycle write is only visible after the edge.
  assign result = mem[index];

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: self-checking bench for data_ram.
// Expected read values come from a reference word array kept by the bench and
// pass through a scoreboard queue before being compared with result.
module tb_data_ram;

  localparam int ADDR_BITS = 10;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic        clock;
  logic        reset;
  logic        store;
  logic [31:0] address;
  logic [31:0] data;
  logic [31:0] result;

  int checks;
  int errors;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];

  data_ram #(.ADDR_BITS(ADDR_BITS)) dut (
    .clock   (clock),
    .reset   (reset),
    .store   (store),
    .address (address),
    .data    (data),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_BITS+1:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an address with store low, queue the expected word, then compare
  // once the combinational read has settled.
  task automatic rd(input string tag, input logic [31:0] a);
    logic [31:0] exp;
    exp_q.push_back(model[widx(a)]);
    store   = 1'b0;
    address = a;
    #1;
    exp = exp_q.pop_front();
    chk(tag, result, exp);
  endtask

  // One-edge store; also checks that the old value is shown before the edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] exp;
    @(negedge clock);
    reset   = 1'b1;
    store   = 1'b1;
    address = a;
    data    = d;
    exp_q.push_back(model[widx(a)]);
    #1;
    exp = exp_q.pop_front();
    chk("pre_wr_old", result, exp);
    @(posedge clock);
    model[widx(a)] = d;
    #1;
    store = 1'b0;
  endtask

  // Reset for a number of edges, optionally with a store pending.
  task automatic do_reset(input int edges, input logic st, input logic [31:0] a,
                          input logic [31:0] d);
    @(negedge clock);
    reset   = 1'b0;
    store   = st;
    address = a;
    data    = d;
    repeat (edges) @(posedge clock);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    #1;
    reset = 1'b1;
    store = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    store   = 1'b0;
    address = 32'h0;
    data    = 32'h0;

    // Reset state
    do_reset(1, 1'b0, 32'h0, 32'h0);
    rd("rst_a0", 32'h0);
    rd("rst_a4", 32'h4);
    rd("rst_top", 32'hFFC);

    // Write then read
    wr(32'd4, 32'd100);
    wr(32'd8, 32'd200);
    rd("wr_a4", 32'd4);
    rd("wr_a8", 32'd8);

    // Reset clears
    do_reset(1, 1'b0, 32'h4, 32'h0);
    rd("clr_a4", 32'd4);
    rd("clr_a8", 32'd8);
    rd("clr_a0", 32'd0);

    // Alignment and aliasing
    wr(32'd4, 32'hDEADBEEF);
    rd("align_5", 32'd5);
    rd("align_6", 32'd6);
    rd("align_7", 32'd7);
    rd("alias_1004", 32'h1004);
    rd("alias_hi", 32'hFFFF_F004);
    rd("align_a0", 32'd0);

    // Reset priority over a same-edge store, held for several edges
    wr(32'd12, 32'h99);
    rd("pre_prio", 32'd12);
    do_reset(3, 1'b1, 32'd12, 32'h55);
    rd("prio_a12", 32'd12);
    rd("prio_a4", 32'd4);

    // Write gating: data/address wander with store low across edges
    wr(32'd4, 32'hAAAA_0004);
    wr(32'd8, 32'hBBBB_0008);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      data = $urandom;
      rd("gate_track", $urandom);
      rd("gate_a4", 32'd4);
      rd("gate_a8", 32'd8);
    end

    // Back-to-back stores on consecutive edges
    wr(32'd16, 32'd1);
    wr(32'd20, 32'd2);
    wr(32'd24, 32'd3);
    rd("b2b_16", 32'd16);
    rd("b2b_20", 32'd20);
    rd("b2b_24", 32'd24);
    wr(32'd16, 32'd7);
    rd("rewr_16", 32'd16);
    rd("rewr_20", 32'd20);

    // Store held across edges to the same word keeps the latest data
    wr(32'd28, 32'h11);
    wr(32'd28, 32'h22);
    rd("hold_28", 32'd28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
